// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: element geometry and the loader phase encoding.
package coproc_pkg;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned N_ELEM = 25;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } phase_e;

endpackage

// File: rtl/matrix_loader.sv
// Streams two row-major matrices element by element into operand registers
// and holds the complete pair until the downstream multiplier acknowledges it.
module matrix_loader #(
    parameter int unsigned ELEM_W = coproc_pkg::ELEM_W,
    parameter int unsigned N_ELEM = coproc_pkg::N_ELEM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [ELEM_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     abort,
    input  logic                     out_ack,
    output logic [N_ELEM*ELEM_W-1:0] matrix_a,
    output logic [N_ELEM*ELEM_W-1:0] matrix_b,
    output logic                     matrices_valid,
    output logic [4:0]               elem_idx,
    output logic [1:0]               phase
);
    import coproc_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(N_ELEM - 1);

    phase_e                    state_q,    state_d;
    logic [4:0]                elem_idx_q, elem_idx_d;
    logic [N_ELEM*ELEM_W-1:0]  matrix_a_q, matrix_a_d;
    logic [N_ELEM*ELEM_W-1:0]  matrix_b_q, matrix_b_d;
    logic                      accept;
    int unsigned               wr_lsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            elem_idx_q <= '0;
            matrix_a_q <= '0;
            matrix_b_q <= '0;
        end else begin
            state_q    <= state_d;
            elem_idx_q <= elem_idx_d;
            matrix_a_q <= matrix_a_d;
            matrix_b_q <= matrix_b_d;
        end
    end

    // Abort overrides both acceptance and out_ack; matrix contents are never cleared here.
    always_comb begin
        state_d    = state_q;
        elem_idx_d = elem_idx_q;
        matrix_a_d = matrix_a_q;
        matrix_b_d = matrix_b_q;
        accept     = in_valid && in_ready && !abort;
        wr_lsb     = 32'(elem_idx_q) * ELEM_W;
        if (abort) begin
            state_d    = LOAD_A;
            elem_idx_d = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        matrix_a_d[wr_lsb +: ELEM_W] = in_data;
                        if (elem_idx_q == LAST_IDX) begin
                            elem_idx_d = '0;
                            state_d    = LOAD_B;
                        end else begin
                            elem_idx_d = elem_idx_q + 5'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        matrix_b_d[wr_lsb +: ELEM_W] = in_data;
                        if (elem_idx_q == LAST_IDX) begin
                            elem_idx_d = '0;
                            state_d    = FULL;
                        end else begin
                            elem_idx_d = elem_idx_q + 5'd1;
                        end
                    end
                end
                FULL: begin
                    if (out_ack) begin
                        state_d    = LOAD_A;
                        elem_idx_d = '0;
                    end
                end
                default: begin
                    state_d    = LOAD_A;
                    elem_idx_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready       = (state_q != FULL);
        matrices_valid = (state_q == FULL);
        phase          = state_q;
        elem_idx       = elem_idx_q;
        matrix_a       = matrix_a_q;
        matrix_b       = matrix_b_q;
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: full load, FULL back-pressure, gapped load,
// abort mid-B, and asynchronous reset mid-A.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         abort;
    logic         out_ack;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic         matrices_valid;
    logic [4:0]   elem_idx;
    logic [1:0]   phase;

    int checks   = 0;
    int failures = 0;

    logic [199:0] exp_a, exp_b, exp_a2, snap_a, snap_b;
    int           cnt, cyc;

    always #5 clk = ~clk;

    matrix_loader #(.ELEM_W(8), .N_ELEM(25)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .abort          (abort),
        .out_ack        (out_ack),
        .matrix_a       (matrix_a),
        .matrix_b       (matrix_b),
        .matrices_valid (matrices_valid),
        .elem_idx       (elem_idx),
        .phase          (phase)
    );

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        abort    = 1'b0;
        out_ack  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            exp_a[i*8 +: 8]  = 8'(i + 1);
            exp_b[i*8 +: 8]  = 8'(i + 26);
            exp_a2[i*8 +: 8] = 8'(8'hA0 + i);
        end

        #12;
        chk("rst_phase",    200'(phase),          200'd0);
        chk("rst_idx",      200'(elem_idx),       200'd0);
        chk("rst_mvalid",   200'(matrices_valid), 200'd0);
        chk("rst_ready",    200'(in_ready),       200'd1);
        chk("rst_mat_a",    matrix_a,             200'd0);
        chk("rst_mat_b",    matrix_b,             200'd0);
        step();
        rst_n = 1'b1;

        // Continuous stream of 1..50
        for (int k = 1; k <= 50; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            step();
            chk("stream_idx", 200'(elem_idx), 200'(k % 25));
            if (k == 49) chk("mvalid_before_50", 200'(matrices_valid), 200'd0);
        end
        in_valid = 1'b0;
        chk("full_phase",  200'(phase),          200'd2);
        chk("full_mvalid", 200'(matrices_valid), 200'd1);
        chk("full_ready",  200'(in_ready),       200'd0);
        chk("a_first",     200'(matrix_a[7:0]),     200'd1);
        chk("a_last",      200'(matrix_a[199:192]), 200'd25);
        chk("b_first",     200'(matrix_b[7:0]),     200'd26);
        chk("b_last",      200'(matrix_b[199:192]), 200'd50);
        chk("mat_a_all",   matrix_a, exp_a);
        chk("mat_b_all",   matrix_b, exp_b);

        // Offers while FULL must be ignored
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            step();
            chk("full_hold_phase", 200'(phase), 200'd2);
            chk("full_hold_a",     matrix_a,    exp_a);
            chk("full_hold_b",     matrix_b,    exp_b);
        end
        in_valid = 1'b0;
        out_ack  = 1'b1;
        step();
        out_ack = 1'b0;
        chk("ack_phase",  200'(phase),          200'd0);
        chk("ack_idx",    200'(elem_idx),       200'd0);
        chk("ack_mvalid", 200'(matrices_valid), 200'd0);
        chk("ack_ready",  200'(in_ready),       200'd1);
        chk("ack_keep_a", matrix_a,             exp_a);

        // out_ack outside FULL is ignored
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        chk("ack_ignored_phase", 200'(phase), 200'd0);

        // Gapped load of 1..50 with ~50% valid duty
        cnt = 0;
        cyc = 0;
        while (cnt < 50 && cyc < 1000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'(cnt + 1);
            step();
            if (in_valid) cnt++;
            cyc++;
            chk("gap_idx", 200'(elem_idx), 200'(cnt % 25));
        end
        in_valid = 1'b0;
        chk("gap_done",   200'(cnt),   200'd50);
        chk("gap_phase",  200'(phase), 200'd2);
        chk("gap_mat_a",  matrix_a,    exp_a);
        chk("gap_mat_b",  matrix_b,    exp_b);

        // Reload A with A0.., then abort at LOAD_B index 10
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + k);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + k);
            step();
        end
        chk("pre_abort_phase", 200'(phase),    200'd1);
        chk("pre_abort_idx",   200'(elem_idx), 200'd10);
        in_valid = 1'b1;
        in_data  = 8'h77;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_phase",   200'(phase),             200'd0);
        chk("abort_idx",     200'(elem_idx),          200'd0);
        chk("abort_mat_a",   matrix_a,                exp_a2);
        chk("abort_b_slot9", 200'(matrix_b[79:72]),   200'hC9);
        chk("abort_b_slot10",200'(matrix_b[87:80]),   200'd36);

        // Asynchronous reset between edges at LOAD_A index 7
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + k);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_idx", 200'(elem_idx), 200'd7);
        snap_a = matrix_a;
        snap_b = matrix_b;
        chk("pre_rst_a_nonzero", 200'(snap_a != 200'd0), 200'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_phase",  200'(phase),          200'd0);
        chk("async_rst_idx",    200'(elem_idx),       200'd0);
        chk("async_rst_mvalid", 200'(matrices_valid), 200'd0);
        chk("async_rst_ready",  200'(in_ready),       200'd1);
        chk("async_rst_mat_a",  matrix_a,             200'd0);
        chk("async_rst_mat_b",  matrix_b,             200'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
